// File: rtl/sr_drv_pkg.sv
// Shared types and helpers for the SR flip-flop driver.
package sr_drv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PULSE  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  localparam int MIN_CNT_W = 1;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? MIN_CNT_W : $clog2(n);
  endfunction

  // Q==Qn is never a valid readback, so it always fails the match.
  function automatic logic match(input logic target, input logic q, input logic qn);
    return (q == target) && (qn == !target);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter with a zero flag; times both the pulse and settle phases.
module cycle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_cnt <= '0;
    else if (i_load)                 r_cnt <= i_load_val;
    else if (i_en && (r_cnt != '0))  r_cnt <= r_cnt - W'(1);
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sr_ff_driver.sv
// Turns a valid/ready write request into a timed S or R pulse, then verifies Q/Qn with retries.
module sr_ff_driver
  import sr_drv_pkg::*;
#(
  parameter  int PULSE_CYCLES  = 2,
  parameter  int SETTLE_CYCLES = 3,
  parameter  int MAX_RETRY     = 3,
  localparam int RW            = cnt_w(MAX_RETRY + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_value,
  output logic          S,
  output logic          R,
  input  logic          Q,
  input  logic          Qn,
  output logic          done,
  output logic          err,
  output logic          busy,
  output logic [RW-1:0] retry_cnt
);

  localparam int TW = cnt_w((PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES);
  // Timer counts down to zero, so phases of N cycles load N-1.
  localparam logic [TW-1:0] P_LOAD = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] S_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRY);

  state_t        r_state;
  logic          r_target;
  logic          r_s, r_r, r_done, r_err;
  logic [RW-1:0] r_retry;

  logic          w_zero, w_accept, w_match_req, w_match_tgt, w_retry, w_tmr_load;
  logic [TW-1:0] w_load_val;

  assign w_accept    = (r_state == ST_IDLE) && req_valid;
  assign w_match_req = match(req_value, Q, Qn);
  assign w_match_tgt = match(r_target, Q, Qn);
  assign w_retry     = (r_state == ST_SETTLE) && w_zero && !w_match_tgt && (r_retry < R_MAX);
  assign w_tmr_load  = (w_accept && !w_match_req) || ((r_state == ST_PULSE) && w_zero) || w_retry;
  assign w_load_val  = (r_state == ST_PULSE) ? S_LOAD : P_LOAD;

  cycle_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_load_val),
    .i_en       (r_state != ST_IDLE),
    .o_zero     (w_zero)
  );

  // S/R are set on the edge entering PULSE and cleared on the edge leaving it,
  // so they only ever come from flops and are never both high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_target <= 1'b0;
      r_s      <= 1'b0;
      r_r      <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_retry  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_target <= req_value;
            r_retry  <= '0;
            if (w_match_req) begin
              r_done <= 1'b1;
              r_err  <= 1'b0;
            end else begin
              r_state <= ST_PULSE;
              r_s     <= req_value;
              r_r     <= !req_value;
            end
          end
        end
        ST_PULSE: begin
          if (w_zero) begin
            r_s     <= 1'b0;
            r_r     <= 1'b0;
            r_state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (w_zero) begin
            if (w_match_tgt) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
              r_err   <= 1'b0;
            end else if (r_retry < R_MAX) begin
              r_retry <= r_retry + RW'(1);
              r_state <= ST_PULSE;
              r_s     <= r_target;
              r_r     <= !r_target;
            end else begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_s     <= 1'b0;
          r_r     <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign busy      = !req_ready;
  assign S         = r_s;
  assign R         = r_r;
  assign done      = r_done;
  assign err       = r_err;
  assign retry_cnt = r_retry;

endmodule
